// File: rtl/lsu_sb_pkg.sv
// lsu_sb_pkg: shared store-buffer entry type and defaults
package lsu_sb_pkg;
  localparam int SB_ADDR_W = 16;
  localparam int SB_DATA_W = 39;
  localparam int SB_MAX_WAIT = 7;
  typedef struct packed {
    logic                 valid;
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
  } sb_entry_t;
endpackage

// File: rtl/sb_fwd_match.sv
// sb_fwd_match: picks the youngest set match bit, age counted from the head index
module sb_fwd_match #(
  parameter int DEPTH = 4,
  parameter int IW = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] i_match,
  input  logic [IW-1:0]    i_head,
  output logic             o_hit,
  output logic [IW-1:0]    o_idx
);
  logic [IW-1:0] w_pos;
  // walk from oldest to youngest so the last match seen is the youngest
  always_comb begin
    o_hit = |i_match;
    o_idx = '0;
    w_pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_pos = i_head + k[IW-1:0];
      if (i_match[w_pos]) o_idx = w_pos;
    end
  end
endmodule

// File: rtl/dccm_store_buffer.sv
// dccm_store_buffer: committed-store FIFO that drains into idle DCCM cycles and forwards to loads
module dccm_store_buffer
  import lsu_sb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = SB_ADDR_W,
  parameter int DATA_W = SB_DATA_W,
  parameter int MAX_WAIT = SB_MAX_WAIT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic              rd_valid,
  output logic              rd_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              fwd_hit,
  output logic [DATA_W-1:0] fwd_data,
  output logic              dccm_wren,
  output logic              dccm_rden,
  output logic [ADDR_W-1:0] dccm_wr_addr,
  output logic [DATA_W-1:0] dccm_wr_data,
  output logic [ADDR_W-1:0] dccm_rd_addr_lo,
  output logic [ADDR_W-1:0] dccm_rd_addr_hi,
  output logic              empty
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  sb_entry_t         r_ent [DEPTH];
  logic [PW-1:0]     r_wr_ptr, r_rd_ptr, r_count;
  logic [WW-1:0]     r_wait;
  logic              r_fwd_hit;
  logic [DATA_W-1:0] r_fwd_data;
  logic              w_empty, w_full, w_force, w_push, w_pop, w_hit;
  logic [DEPTH-1:0]  w_match;
  logic [IW-1:0]     w_idx;
  sb_entry_t         w_head;
  assign w_empty = r_count == '0;
  assign w_full = r_count == PW'(DEPTH);
  assign w_force = !w_empty & (w_full | r_wait == WW'(MAX_WAIT));
  assign w_head = r_ent[r_rd_ptr[IW-1:0]];
  assign st_ready = !rst & !w_full;
  assign rd_ready = !rst & rd_valid & !w_force;
  assign dccm_rden = rd_ready;
  assign dccm_wren = !rst & !w_empty & !freeze & (w_force | !rd_valid);
  assign dccm_wr_addr = w_head.addr;
  assign dccm_wr_data = w_head.data;
  assign dccm_rd_addr_lo = rd_addr;
  assign dccm_rd_addr_hi = rd_addr + ADDR_W'(4);
  assign empty = rst | w_empty;
  assign fwd_hit = r_fwd_hit;
  assign fwd_data = r_fwd_data;
  assign w_push = st_valid & st_ready;
  assign w_pop = dccm_wren;
  // word-address compare of the load against every live entry, including one being popped
  always_comb begin
    w_match = '0;
    for (int i = 0; i < DEPTH; i++)
      w_match[i] = r_ent[i].valid & (r_ent[i].addr[ADDR_W-1:2] == rd_addr[ADDR_W-1:2]);
  end
  sb_fwd_match #(.DEPTH(DEPTH)) u_match (
    .i_match(w_match),
    .i_head (r_rd_ptr[IW-1:0]),
    .o_hit  (w_hit),
    .o_idx  (w_idx)
  );
  // FIFO storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_ent[i].valid <= 1'b0;
    end else begin
      if (w_pop) r_ent[r_rd_ptr[IW-1:0]].valid <= 1'b0;
      if (w_push) r_ent[r_wr_ptr[IW-1:0]] <= sb_entry_t'{valid: 1'b1, addr: st_addr, data: st_data};
      r_wr_ptr <= r_wr_ptr + PW'(w_push);
      r_rd_ptr <= r_rd_ptr + PW'(w_pop);
      r_count <= r_count + PW'(w_push) - PW'(w_pop);
    end
  end
  // head starvation counter: cleared by a drain or an empty buffer, held by freeze
  always_ff @(posedge clk) begin
    if (rst || w_empty || w_pop) r_wait <= '0;
    else if (!freeze && r_wait != WW'(MAX_WAIT)) r_wait <= r_wait + 1'b1;
  end
  // forwarding result lines up with the DCCM read data of the issued load
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fwd_hit <= 1'b0;
      r_fwd_data <= '0;
    end else if (rd_ready) begin
      r_fwd_hit <= w_hit;
      r_fwd_data <= w_hit ? r_ent[w_idx].data : '0;
    end else r_fwd_hit <= 1'b0;
  end
endmodule

// File: tb/tb_dccm_store_buffer.sv
// tb_dccm_store_buffer: directed and randomized checks against a queue-based model
module tb_dccm_store_buffer;
  localparam int DEPTH = 4;
  localparam int MW = 7;
  logic        clk = 1'b0, rst = 1'b1, freeze = 1'b0;
  logic        st_valid = 1'b0, rd_valid = 1'b0;
  logic [15:0] st_addr = '0, rd_addr = '0;
  logic [38:0] st_data = '0;
  logic        st_ready, rd_ready, fwd_hit, dccm_wren, dccm_rden, empty;
  logic [38:0] fwd_data, dccm_wr_data;
  logic [15:0] dccm_wr_addr, dccm_rd_addr_lo, dccm_rd_addr_hi;
  int checks = 0, errors = 0;
  dccm_store_buffer dut (
    .clk(clk), .rst(rst), .freeze(freeze),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data),
    .dccm_wren(dccm_wren), .dccm_rden(dccm_rden),
    .dccm_wr_addr(dccm_wr_addr), .dccm_wr_data(dccm_wr_data),
    .dccm_rd_addr_lo(dccm_rd_addr_lo), .dccm_rd_addr_hi(dccm_rd_addr_hi),
    .empty(empty)
  );
  always #5 clk = ~clk;
  typedef struct { logic [15:0] a; logic [38:0] d; } ent_t;
  ent_t q[$];
  int mwait = 0;
  logic m_hit = 1'b0;
  logic [38:0] m_data = '0;
  logic e_st_ready, e_rd_ready, e_wren, e_empty, e_fh;
  logic [38:0] e_fd;
  task automatic predict();
    int n;
    logic frc;
    n = q.size();
    frc = n > 0 && (n == DEPTH || mwait == MW);
    e_st_ready = !rst && n != DEPTH;
    e_rd_ready = !rst && rd_valid && !frc;
    e_wren = !rst && n > 0 && !freeze && (frc || !rd_valid);
    e_empty = rst || n == 0;
    e_fh = 1'b0;
    e_fd = '0;
    for (int i = 0; i < n; i++)
      if (q[i].a[15:2] == rd_addr[15:2]) begin e_fh = 1'b1; e_fd = q[i].d; end
  endtask
  task automatic drive(input logic sv, input logic [15:0] sa, input logic [38:0] sd,
                       input logic rv, input logic [15:0] ra, input logic fz, input logic r);
    st_valid = sv; st_addr = sa; st_data = sd;
    rd_valid = rv; rd_addr = ra; freeze = fz; rst = r;
    #1;
    predict();
  endtask
  task automatic advance();
    int n;
    ent_t e;
    @(posedge clk);
    if (rst) begin
      q.delete(); mwait = 0; m_hit = 1'b0; m_data = '0;
    end else begin
      n = q.size();
      if (e_rd_ready) begin m_hit = e_fh; m_data = e_fd; end else m_hit = 1'b0;
      if (e_wren) void'(q.pop_front());
      if (n == 0 || e_wren) mwait = 0;
      else if (!freeze && mwait < MW) mwait++;
      if (st_valid && e_st_ready) begin e.a = st_addr; e.d = st_data; q.push_back(e); end
    end
    #1;
  endtask
  task automatic test_reset();
    drive(1, 16'h0010, 39'h1, 1, 16'h0010, 0, 1);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_st_ready: got %b expected 0", st_ready); end
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
    checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL reset_wren: got %b expected 0", dccm_wren); end
    checks++; if (dccm_rden !== 1'b0) begin errors++; $display("FAIL reset_rden: got %b expected 0", dccm_rden); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL reset_fwd_hit: got %b expected 0", fwd_hit); end
    checks++; if (empty !== 1'b1 || st_ready !== 1'b1) begin errors++; $display("FAIL post_reset: empty %b st_ready %b expected 1 1", empty, st_ready); end
    advance();
  endtask
  task automatic test_write_drain();
    drive(1, 16'h0010, 39'h1A5A5A5A5, 0, 0, 0, 0);
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (dccm_wren !== 1'b1) begin errors++; $display("FAIL drain_wren: got %b expected 1", dccm_wren); end
    checks++; if (dccm_wr_addr !== 16'h0010) begin errors++; $display("FAIL drain_addr: got %h expected 0010", dccm_wr_addr); end
    checks++; if (dccm_wr_data !== 39'h1A5A5A5A5) begin errors++; $display("FAIL drain_data: got %h expected 1a5a5a5a5", dccm_wr_data); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1 || dccm_wren !== 1'b0) begin errors++; $display("FAIL drain_empty: empty %b wren %b expected 1 0", empty, dccm_wren); end
    advance();
  endtask
  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      drive(1, 16'h0500 + 16'(4 * k), 39'h500 + 39'(k), 1, 16'h0900, 0, 0);
      checks++; if (rd_ready !== 1'b1 || dccm_wren !== 1'b0) begin errors++; $display("FAIL fill_read_wins[%0d]: rd_ready %b wren %b expected 1 0", k, rd_ready, dccm_wren); end
      advance();
    end
    drive(0, 0, 0, 1, 16'h0900, 0, 0);
    checks++; if (st_ready !== 1'b0) begin errors++; $display("FAIL fill_st_ready: got %b expected 0", st_ready); end
    checks++; if (rd_ready !== 1'b0 || dccm_wren !== 1'b1) begin errors++; $display("FAIL fill_force: rd_ready %b wren %b expected 0 1", rd_ready, dccm_wren); end
    checks++; if (dccm_wr_addr !== 16'h0500) begin errors++; $display("FAIL fill_force_addr: got %h expected 0500", dccm_wr_addr); end
    advance();
    drive(0, 0, 0, 1, 16'h0900, 0, 0);
    checks++; if (st_ready !== 1'b1 || rd_ready !== 1'b1) begin errors++; $display("FAIL fill_after: st_ready %b rd_ready %b expected 1 1", st_ready, rd_ready); end
    advance();
    for (int k = 0; k < 3; k++) begin drive(0, 0, 0, 0, 0, 0, 0); advance(); end
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL fill_drained: got %b expected 1", empty); end
  endtask
  task automatic test_starvation();
    drive(1, 16'h0400, 39'h44, 1, 16'h0800, 0, 0);
    advance();
    for (int c = 1; c <= 7; c++) begin
      drive(0, 0, 0, 1, 16'h0800, 0, 0);
      checks++; if (rd_ready !== 1'b1 || dccm_wren !== 1'b0) begin errors++; $display("FAIL starve_read[%0d]: rd_ready %b wren %b expected 1 0", c, rd_ready, dccm_wren); end
      advance();
    end
    drive(0, 0, 0, 1, 16'h0800, 0, 0);
    checks++; if (rd_ready !== 1'b0 || dccm_wren !== 1'b1 || dccm_rden !== 1'b0) begin errors++; $display("FAIL starve_force: rd_ready %b wren %b rden %b expected 0 1 0", rd_ready, dccm_wren, dccm_rden); end
    advance();
    drive(0, 0, 0, 1, 16'h0800, 0, 0);
    checks++; if (empty !== 1'b1 || rd_ready !== 1'b1) begin errors++; $display("FAIL starve_after: empty %b rd_ready %b expected 1 1", empty, rd_ready); end
    advance();
  endtask
  task automatic test_forwarding();
    drive(1, 16'h0020, 39'h0AAAA0001, 0, 0, 1, 0); advance();
    drive(1, 16'h0020, 39'h0BBBB0002, 0, 0, 1, 0); advance();
    drive(0, 0, 0, 1, 16'h0022, 1, 0);
    checks++; if (rd_ready !== 1'b1 || dccm_wren !== 1'b0) begin errors++; $display("FAIL fwd_issue: rd_ready %b wren %b expected 1 0", rd_ready, dccm_wren); end
    advance();
    drive(0, 0, 0, 1, 16'h0024, 1, 0);
    checks++; if (fwd_hit !== 1'b1) begin errors++; $display("FAIL fwd_hit: got %b expected 1", fwd_hit); end
    checks++; if (fwd_data !== 39'h0BBBB0002) begin errors++; $display("FAIL fwd_data: got %h expected 0bbbb0002", fwd_data); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_miss: got %b expected 0", fwd_hit); end
    checks++; if (dccm_wren !== 1'b1 || dccm_wr_data !== 39'h0AAAA0001) begin errors++; $display("FAIL fwd_drain_a: wren %b data %h expected 1 0aaaa0001", dccm_wren, dccm_wr_data); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (dccm_wren !== 1'b1 || dccm_wr_data !== 39'h0BBBB0002) begin errors++; $display("FAIL fwd_drain_b: wren %b data %h expected 1 0bbbb0002", dccm_wren, dccm_wr_data); end
    advance();
  endtask
  task automatic test_wrap();
    int nxt = 0;
    drive(0, 0, 0, 0, 16'hFFFC, 0, 0);
    checks++; if (dccm_rd_addr_hi !== 16'h0000 || dccm_rd_addr_lo !== 16'hFFFC) begin errors++; $display("FAIL wrap_addr: lo %h hi %h expected fffc 0000", dccm_rd_addr_lo, dccm_rd_addr_hi); end
    for (int c = 0; c < 11; c++) begin
      if (c < 10) drive(1, 16'h0200 + 16'(4 * c), 39'h100 + 39'(c), 0, 0, 0, 0);
      else drive(0, 0, 0, 0, 0, 0, 0);
      if (c > 0) begin
        checks++; if (dccm_wren !== 1'b1 || dccm_wr_data !== 39'h100 + 39'(nxt)) begin errors++; $display("FAIL wrap_order[%0d]: wren %b data %h expected 1 %h", c, dccm_wren, dccm_wr_data, 39'h100 + 39'(nxt)); end
        nxt++;
      end
      advance();
    end
  endtask
  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive(1, 16'h0300 + 16'(4 * k), 39'h300 + 39'(k), k == 2, 16'h0300, 1, 0);
      advance();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 39'h300) begin errors++; $display("FAIL mid_pre_fwd: hit %b data %h expected 1 300", fwd_hit, fwd_data); end
    checks++; if (dccm_wren !== 1'b0) begin errors++; $display("FAIL mid_rst_wren: got %b expected 0", dccm_wren); end
    advance();
    drive(0, 0, 0, 0, 0, 0, 0);
    checks++; if (empty !== 1'b1 || dccm_wren !== 1'b0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL mid_after: empty %b wren %b fwd_hit %b expected 1 0 0", empty, dccm_wren, fwd_hit); end
    advance();
  endtask
  task automatic test_random();
    logic [15:0] hi;
    for (int c = 0; c < 1500; c++) begin
      drive($urandom_range(0, 99) < 45, 16'h0040 + 16'(4 * $urandom_range(0, 3)), 39'($urandom()) ^ {7'($urandom()), 32'h0},
            $urandom_range(0, 99) < 55, 16'h0040 + 16'($urandom_range(0, 15)), $urandom_range(0, 99) < 15, $urandom_range(0, 199) == 0);
      hi = rd_addr + 16'd4;
      checks++; if (st_ready !== e_st_ready) begin errors++; $display("FAIL rnd_st_ready[%0d]: got %b expected %b", c, st_ready, e_st_ready); end
      checks++; if (rd_ready !== e_rd_ready || dccm_rden !== e_rd_ready) begin errors++; $display("FAIL rnd_rd_ready[%0d]: got %b/%b expected %b", c, rd_ready, dccm_rden, e_rd_ready); end
      checks++; if (dccm_wren !== e_wren) begin errors++; $display("FAIL rnd_wren[%0d]: got %b expected %b", c, dccm_wren, e_wren); end
      checks++; if (empty !== e_empty) begin errors++; $display("FAIL rnd_empty[%0d]: got %b expected %b", c, empty, e_empty); end
      checks++; if (fwd_hit !== m_hit) begin errors++; $display("FAIL rnd_fwd_hit[%0d]: got %b expected %b", c, fwd_hit, m_hit); end
      checks++; if (dccm_rd_addr_hi !== hi) begin errors++; $display("FAIL rnd_rd_hi[%0d]: got %h expected %h", c, dccm_rd_addr_hi, hi); end
      if (m_hit) begin
        checks++; if (fwd_data !== m_data) begin errors++; $display("FAIL rnd_fwd_data[%0d]: got %h expected %h", c, fwd_data, m_data); end
      end
      if (e_wren) begin
        checks++; if (dccm_wr_addr !== q[0].a || dccm_wr_data !== q[0].d) begin errors++; $display("FAIL rnd_wr[%0d]: got %h/%h expected %h/%h", c, dccm_wr_addr, dccm_wr_data, q[0].a, q[0].d); end
      end
      advance();
    end
  endtask
  initial begin
    @(posedge clk); #1;
    test_reset();
    test_write_drain();
    test_fill();
    advance();
    test_starvation();
    test_forwarding();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dccm_store_buffer.md
# dccm_store_buffer

Store buffer and DCCM port scheduler. It sits directly upstream of the DCCM macro wrapper and drives that wrapper's `dccm_wren`/`dccm_rden`, `dccm_wr_addr`/`dccm_rd_addr_lo`/`dccm_rd_addr_hi` and `dccm_wr_data` ports. It holds committed LSU stores in a small FIFO and drains them in idle DCCM cycles, with anti-starvation forcing. It also forwards buffered store data to loads so that load data stays coherent with pending writes.

## Interface
Parameters:
- DEPTH, 4, number of store entries (power of two, ≥2)
- ADDR_W, 16, DCCM byte-address width (`RV_DCCM_BITS`)
- DATA_W, 39, DCCM data word incl. ECC (`RV_DCCM_FDATA_WIDTH`)
- MAX_WAIT, 7, cycles a head entry may be blocked before writes take priority

Ports:
- clk  in  1  core clock; everything is synchronous to its rising edge
- rst  in  1  synchronous, active-high reset
- freeze  in  1  LSU freeze (`lsu_freeze_dc3`); while high, nothing drains
- st_valid  in  1  store request
- st_ready  out  1  buffer can accept a store
- st_addr  in  ADDR_W  store byte address, word aligned
- st_data  in  DATA_W  store word with ECC
- rd_valid  in  1  load request
- rd_ready  out  1  load is issued to the DCCM this cycle
- rd_addr  in  ADDR_W  load byte address
- fwd_hit  out  1  registered: the load issued last cycle matched a buffered store
- fwd_data  out  DATA_W  registered: youngest matching store data
- dccm_wren  out  1  to the DCCM wrapper
- dccm_rden  out  1  to the DCCM wrapper
- dccm_wr_addr  out  ADDR_W  to the DCCM wrapper
- dccm_wr_data  out  DATA_W  to the DCCM wrapper
- dccm_rd_addr_lo  out  ADDR_W  to the DCCM wrapper
- dccm_rd_addr_hi  out  ADDR_W  to the DCCM wrapper
- empty  out  1  no valid entries

## Operation
- **FIFO:** DEPTH entries, each holding valid, addr and data. Write pointer, read pointer and count are sized clog2(DEPTH)+1 wide. Pointers wrap modulo DEPTH.
- **Store acceptance:** `st_ready = (count != DEPTH)`. Push on `st_valid & st_ready`. `st_ready` does not account for a same-cycle pop.
- **Arbiter modes** (combinational select from registered state):
  - READ_PRIO when `!force`: `rd_ready = rd_valid`.
    - If `rd_valid`: `dccm_rden = 1`, no write.
    - Otherwise, if the buffer is non-empty and `!freeze`: `dccm_wren = 1` for the head entry.
  - WRITE_FORCE when `force`: `rd_ready = 0`. The head drains if `!freeze`.
  - `force = !empty & (count == DEPTH | wait_cnt == MAX_WAIT)`.
- **Pop:** occurs on the edge where `dccm_wren` is high. `dccm_wr_addr` and `dccm_wr_data` always show the head entry.
- **wait_cnt:** resets to 0 on pop and while empty. Otherwise it increments each cycle the head is not popped and saturates at MAX_WAIT.
- **freeze:** blocks pops, leaves `wait_cnt` frozen, and still allows pushes and reads.
- **Read addressing:**
  - `dccm_rd_addr_lo = rd_addr`
  - `dccm_rd_addr_hi = rd_addr + 4`, modulo 2^ADDR_W (wraps at the top of the address space).
  - Both are driven regardless of `rd_ready`.
- **Forwarding:**
  - Compare `rd_addr[ADDR_W-1:2]` against all valid entries. The youngest match wins (age is measured from the read pointer).
  - The entry being popped in the same cycle still counts as a match. A store being pushed in the same cycle does not.
  - Result is registered when `rd_valid & rd_ready`; otherwise `fwd_hit` is cleared to 0.
- **Simultaneous push and pop:** count is unchanged and both pointers advance.

## Timing
- **Reset values:** count, pointers, `wait_cnt`, all entry valids, `fwd_hit` and `fwd_data` are 0.
- **Outputs while in reset:** `st_ready = 0`, `empty = 1`, `dccm_wren = 0`, `dccm_rden = 0`.
- **Reset mid-operation:** all buffered stores are discarded with no partial write.
- **Push to write:** a pushed store is first drainable on the next cycle, so minimum push-to-`dccm_wren` latency is 1 cycle.
- **Forwarding latency:** `fwd_hit`/`fwd_data` are valid 1 cycle after issue, aligned with DCCM read data.
- **Per-cycle limits:** at most one DCCM access (read or write) per cycle.
- **Worst-case load stall:** 1 cycle per forced drain while un-frozen.

## Structure
- Package `lsu_sb_pkg` holds a packed entry typedef `sb_entry_t {valid, addr, data}` and the MAX_WAIT default.
- Optional sub-module `sb_fwd_match`: a parametric youngest-match priority selector.
- Target size 150–250 lines of RTL.

## Test plan
- **Write drain:** one store at `0x0010`, data `0x1A5A5A5A5`, no loads → `dccm_wren` on cycle 1 with addr `0x0010`; `empty = 1` on cycle 2.
- **Fill:** 4 back-to-back stores with `rd_valid` held high → `st_ready = 0` after the 4th push; force triggers and drains 1 entry; `rd_ready = 0` in that cycle.
- **Starvation:** 1 store plus continuous `rd_valid` → reads win for 7 cycles; on the cycle `wait_cnt = 7`, `rd_ready = 0` and `dccm_wren = 1`.
- **Forwarding:** stores to `0x0020` with data A, then data B, with freeze held high; load `0x0022` → next cycle `fwd_hit = 1`, `fwd_data = B`. Load `0x0024` → `fwd_hit = 0`.
- **Wrap:** load at `0xFFFC` with ADDR_W=16 → `dccm_rd_addr_hi = 0x0000`. Also push and pop through 10 entries and confirm in-order writes across pointer wrap.
- **Reset mid-operation:** assert `rst` with 3 entries buffered → next cycle `empty = 1`, no `dccm_wren`, `fwd_hit = 0`.
